// File: rtl/press_gen.sv
// press_gen -- button press waveform generator
//
// Generates cnt_i presses on b_o after a request. Each press holds b_o
// high for HOLD_CYCLES cycles, then low for GAP_CYCLES cycles. This gives
// a clean press-then-release shape for a downstream press-release
// detector. A one-cycle done_o pulse marks the end of the sequence.
//
// Parameters:
//   HOLD_CYCLES  cycles b_o is high per press (1..255)
//   GAP_CYCLES   cycles b_o is low after each press (1..255)
//   CNT_W        width of the press-count request
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   req_i    request a press sequence (accepted while ready_o=1)
//   cnt_i    number of presses, captured on acceptance
//   ready_o  high only while idle
//   b_o      registered button waveform, high exactly in the HOLD state
//   busy_o   high while presses are being generated
//   done_o   one-cycle completion pulse
//   abort_i  (only with PRESS_GEN_ABORT_EN) cancels an in-progress sequence
//
// Configuration macro: PRESS_GEN_ABORT_EN adds abort_i. Without it,
// a sequence ends only through DONE or reset.
module press_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             ready_o,
  output logic             b_o,
  output logic             busy_o,
  output logic             done_o
`ifdef PRESS_GEN_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  // Reject out-of-range parameters at elaboration.
  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("press_gen: HOLD_CYCLES must be in 1..255");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("press_gen: GAP_CYCLES must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("press_gen: CNT_W must be at least 1");
    end
  endgenerate

  localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PH_W      = $clog2(MAX_PHASE + 1);

  // The phase counter counts down to zero. Loading length-1 makes each
  // phase last exactly its configured number of cycles.
  localparam logic [PH_W-1:0] HOLD_LOAD = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LOAD  = PH_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_next;
  logic             b_reg;
  logic             abort_now;

`ifdef PRESS_GEN_ABORT_EN
  assign abort_now = abort_i;
`else
  assign abort_now = 1'b0;
`endif

  // Next-state logic plus the phase and press counters. The remaining count
  // is compared against 1 before decrementing. This avoids any wrap for the
  // largest cnt_i value, and the counter ends at zero once DONE is reached.
  always_comb begin
    next_state     = state;
    phase_next     = phase;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (req_i) begin
          remaining_next = cnt_i;
          if (cnt_i != '0) begin
            next_state = HOLD;
            phase_next = HOLD_LOAD;
          end else begin
            next_state = DONE;
          end
        end
      end
      HOLD: begin
        if (phase == '0) begin
          next_state = GAP;
          phase_next = GAP_LOAD;
        end else begin
          phase_next = phase - 1'b1;
        end
      end
      GAP: begin
        if (phase == '0) begin
          remaining_next = remaining - 1'b1;
          if (remaining != CNT_W'(1)) begin
            next_state = HOLD;
            phase_next = HOLD_LOAD;
          end else begin
            next_state = DONE;
          end
        end else begin
          phase_next = phase - 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // An abort overrides any phase-end transition in the same cycle.
    if (abort_now && (state == HOLD || state == GAP)) begin
      next_state     = IDLE;
      phase_next     = '0;
      remaining_next = '0;
    end
  end

  // State and counter registers. b_o is registered from the next state, so
  // it is high in exactly the cycles where the state register holds HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      remaining <= '0;
      b_reg     <= 1'b0;
    end else begin
      state     <= next_state;
      phase     <= phase_next;
      remaining <= remaining_next;
      b_reg     <= (next_state == HOLD);
    end
  end

  assign b_o     = b_reg;
  assign ready_o = (state == IDLE);
  assign busy_o  = (state == HOLD) || (state == GAP);
  assign done_o  = (state == DONE);

endmodule

// File: doc/press_gen.md
PRESS_GEN -- requirements
Module: press_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, meaning cycles b_o is held high per press (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, meaning cycles b_o is held low after each press (legal range 1..255).
REQ-003 The block SHALL have parameter CNT_W, default 4, meaning the width of the press-count request.
REQ-004 The block SHALL have port clk  input  1  as the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  as a synchronous, active-high reset.
REQ-006 The block SHALL have port req_i  input  1  requesting a press sequence.
REQ-007 The block SHALL have port cnt_i  input  CNT_W  giving the number of presses to generate.
REQ-008 The block SHALL have port ready_o  output  1  indicating a request can be accepted.
REQ-009 The block SHALL have port b_o  output  1  as the generated button waveform, in press-then-release form for a press-release detector.
REQ-010 The block SHALL have port busy_o  output  1  indicating a sequence is in progress.
REQ-011 The block SHALL have port done_o  output  1  as a one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, HOLD, GAP and DONE.
REQ-013 ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 in HOLD and GAP; done_o SHALL be 1 only in DONE.
REQ-014 b_o SHALL be registered and SHALL be 1 exactly while the state is HOLD.
REQ-015 A request SHALL be accepted on a clock edge where req_i=1 and ready_o=1; cnt_i SHALL be captured into a remaining-press counter at that edge.
REQ-016 On acceptance with cnt_i!=0, the next state SHALL be HOLD; with cnt_i=0, the next state SHALL be DONE and b_o SHALL stay 0.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles, then the FSM SHALL move to GAP.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, and the remaining count SHALL be decremented on GAP exit.
REQ-019 On GAP exit, the FSM SHALL go to HOLD if the decremented count is nonzero; otherwise it SHALL go to DONE.
REQ-020 DONE SHALL last exactly one cycle, then the FSM SHALL go to IDLE.
REQ-021 A sequence of N presses SHALL take exactly N*(HOLD_CYCLES+GAP_CYCLES) cycles from the first HOLD cycle to the first DONE cycle.
REQ-022 req_i and cnt_i SHALL be ignored outside IDLE; a request held high through DONE SHALL be accepted in the first IDLE cycle, so there is at most one idle cycle between sequences.
REQ-023 cnt_i = 2^CNT_W-1 SHALL produce that many presses, with no wrap of the remaining counter.
REQ-024 The phase counter SHALL be sized to hold max(HOLD_CYCLES, GAP_CYCLES) and SHALL reload at every HOLD and GAP entry.
REQ-025 Parameter values of 0 SHALL be rejected at elaboration.

Reset
REQ-026 While rst=1 at a clock edge: state SHALL become IDLE, b_o=0, busy_o=0, done_o=0, ready_o=1 from the next cycle, and all counters SHALL be 0.
REQ-027 Reset asserted mid-HOLD or mid-GAP SHALL abandon the sequence with no done_o pulse, and b_o SHALL be 0 from the next cycle.
REQ-028 A request present in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-029 With macro PRESS_GEN_ABORT_EN defined, the block SHALL add port abort_i (input, 1 bit).
REQ-030 With PRESS_GEN_ABORT_EN defined, abort_i=1 in HOLD or GAP SHALL move the FSM to IDLE on the next edge, with b_o=0 and no done_o pulse.
REQ-031 With PRESS_GEN_ABORT_EN defined, abort_i SHALL be ignored in IDLE and DONE.
REQ-032 With PRESS_GEN_ABORT_EN defined, abort_i SHALL take priority over a phase-end transition in the same cycle.
REQ-033 Without PRESS_GEN_ABORT_EN, port abort_i SHALL not exist, and sequences SHALL end only via DONE or reset.

Verification
REQ-034 Defaults, one-cycle req_i with cnt_i=1 -> b_o high cycles 1-4 after acceptance, low cycles 5-8, done_o at cycle 9, ready_o at cycle 10.
REQ-035 Defaults, cnt_i=3 -> three 4-high/4-low pulses, done_o exactly 24 cycles after the first b_o rise, busy_o high for all 24 cycles.
REQ-036 cnt_i=0 -> b_o never rises, done_o one cycle after acceptance, busy_o stays 0.
REQ-037 HOLD_CYCLES=1, GAP_CYCLES=2, req_i held high with cnt_i=2 -> two back-to-back sequences, each 6 cycles, separated by the DONE cycle and one IDLE cycle; cnt_i changes mid-sequence have no effect.
REQ-038 rst pulsed in the 3rd HOLD cycle of a cnt_i=5 sequence -> b_o=0 on the next cycle, no done_o, ready_o=1.
REQ-039 With PRESS_GEN_ABORT_EN defined, abort_i in the 2nd GAP cycle of the first press of cnt_i=2 -> IDLE on the next cycle, no further b_o rise, no done_o; without the macro, the same test compiles with abort_i absent.
